// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request in flight, fixed access latency,
// RV32I byte/half/word lanes with extension and access-fault reporting.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_acc;
    logic        w_commit;
    logic        w_we;
    logic [2:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wword;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign w_acc     = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accept edge, so use live inputs.
    assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_size  = (r_state == S_IDLE) ? req_size  : r_size;
    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_commit = (w_state_nxt == S_RESP) && (r_state != S_RESP) && !rst;

    always_comb begin
        w_err = 1'b0;
        if (w_size == 3'b011 || w_size == 3'b110 || w_size == 3'b111)
            w_err = 1'b1;
        if (w_we && w_size[2])
            w_err = 1'b1;
        if (w_size[1:0] == 2'b01 && w_addr[0])
            w_err = 1'b1;
        if (w_size == 3'b010 && w_addr[1:0] != 2'b00)
            w_err = 1'b1;
        if ({1'b0, w_addr} >= LIMIT)
            w_err = 1'b1;
    end

    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wword = 32'd0;
        case (w_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wword = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wword = w_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wword = 32'd0;
            end
        endcase
    end

    // RAM contents survive reset; w_commit already excludes reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against an
// arithmetic memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] mmem [int];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    function automatic void model(input logic we, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int unsigned w;
        int unsigned sh;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] b;
        logic [31:0] h;
        w  = a / 4;
        sh = (a % 4) * 8;
        er = (sz == 3 || sz == 6 || sz == 7) || (we && (sz == 4 || sz == 5)) ||
             ((sz == 1 || sz == 5) && (a % 2) != 0) ||
             (sz == 2 && (a % 4) != 0) || (a >= DEPTH * 4);
        rd = 32'd0;
        if (er) return;
        word = mmem.exists(int'(w)) ? mmem[int'(w)] : 32'd0;
        if (we) begin
            mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
            mmem[int'(w)] = (word & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            b = (word >> sh) % 256;
            h = (word >> sh) % 65536;
            case (sz)
                3'd0: rd = (b >= 128) ? b - 32'd256 : b;
                3'd1: rd = (h >= 32768) ? h - 32'd65536 : h;
                3'd4: rd = b;
                3'd5: rd = h;
                default: rd = word;
            endcase
        end
    endfunction

    task automatic do_op(input logic we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic [31:0] erd, output logic eer);
        int g;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(we, sz, a, wd, erd, eer);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL op_timeout addr=%h: no rsp_valid within %0d cycles", a, lat);
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
                bad++;
                $display("FAIL reset_hold got rdy=%b vld=%b rdata=%h want 0 0 0",
                         req_ready, rsp_valid, rsp_rdata);
            end
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release req_ready got %b want 1", req_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_noaccept got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        do_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat, erd, eer);
        total++;
        if (er !== 1'b0 || lat != LAT) begin
            bad++;
            $display("FAIL word_sw got err=%b lat=%0d want 0 %0d", er, lat, LAT);
        end
        do_op(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, erd, eer);
        total++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != LAT) begin
            bad++;
            $display("FAIL word_lw got rdata=%h err=%b lat=%0d want deadbeef 0 %0d",
                     rd, er, lat, LAT);
        end
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL word_after_hs got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic        we_t [7] = '{1, 0, 0, 0, 1, 0, 0};
        logic [2:0]  sz_t [7] = '{0, 0, 4, 2, 1, 5, 1};
        logic [31:0] ad_t [7] = '{32'h13, 32'h13, 32'h13, 32'h10, 32'h10, 32'h10, 32'h12};
        logic [31:0] wd_t [7] = '{32'h80, 0, 0, 0, 32'h1234, 0, 0};
        logic [31:0] ex_t [7] = '{0, 32'hFFFF_FF80, 32'h80, 32'h80AD_BEEF, 0,
                                  32'h1234, 32'hFFFF_80AD};
        for (int i = 0; i < 7; i++) begin
            do_op(we_t[i], sz_t[i], ad_t[i], wd_t[i], rd, er, lat, erd, eer);
            total++;
            if (rd !== ex_t[i] || er !== 1'b0) begin
                bad++;
                $display("FAIL lanes_%0d got rdata=%h err=%b want %h 0", i, rd, er, ex_t[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        logic        we_t [4] = '{0, 1, 1, 0};
        logic [2:0]  sz_t [4] = '{1, 2, 4, 2};
        logic [31:0] ad_t [4] = '{32'h11, 32'h12, 32'h10, DEPTH * 4};
        logic [31:0] wd_t [4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
        for (int i = 0; i < 4; i++) begin
            do_op(we_t[i], sz_t[i], ad_t[i], wd_t[i], rd, er, lat, erd, eer);
            total++;
            if (rd !== 32'd0 || er !== 1'b1) begin
                bad++;
                $display("FAIL err_%0d got rdata=%h err=%b want 0 1", i, rd, er);
            end
        end
        do_op(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, erd, eer);
        total++;
        if (rd !== 32'h80AD_1234 || er !== 1'b0) begin
            bad++;
            $display("FAIL err_nowrite got rdata=%h err=%b want 80ad1234 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int g;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_size = 3'b101;
        req_addr = 32'h12;
        g = 0;
        while (!rsp_valid && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AD_1234 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold got vld=%b rdata=%h err=%b rdy=%b want 1 80ad1234 0 0",
                         rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        g = 0;
        while (!rsp_valid && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        total++;
        if (g != LAT || rsp_rdata !== 32'h0000_80AD || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_second got lat=%0d rdata=%h err=%b want %0d 000080ad 0",
                     g, rsp_rdata, rsp_err, LAT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        int seen;
        do_op(1'b1, 3'b010, 32'h20, 32'hAAAA_AAAA, rd, er, lat, erd, eer);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rstmid_norsp got %0d response cycles want 0", seen);
        end
        do_op(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, erd, eer);
        total++;
        if (rd !== 32'hAAAA_AAAA || er !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_data got rdata=%h err=%b want aaaaaaaa 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic er, eer, we;
        logic [2:0] sz;
        int lat;
        logic [2:0] sizes [7] = '{0, 1, 2, 4, 5, 3, 6};
        for (int i = 0; i < 8; i++)
            do_op(1'b1, 3'b010, 32'h40 + 32'(i * 4), $urandom, rd, er, lat, erd, eer);
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = sizes[$urandom_range(0, 6)];
            wd = $urandom;
            if ($urandom_range(0, 9) == 0)
                a = 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
            else
                a = 32'h40 + 32'($urandom_range(0, 31));
            do_op(we, sz, a, wd, rd, er, lat, erd, eer);
            total++;
            if (rd !== erd || er !== eer || lat != LAT) begin
                bad++;
                $display("FAIL rand_%0d we=%b sz=%0d a=%h got rdata=%h err=%b lat=%0d want %h %b %0d",
                         i, we, sz, a, rd, er, lat, erd, eer, LAT);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
